// File: rtl/alu_issue.sv
// Execute-issue stage feeding a one-cycle registered ALU: decode, operand select, RAW interlock.
// Define ALU_ISSUE_FWD_EN to forward alu_result; otherwise hazards stall until writeback completes.
module alu_issue #(
  parameter int FWD_DEPTH = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clk_en,
  input  logic        i_flush,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic [31:0] i_alu_result,
  output logic [31:0] o_operand_a,
  output logic [31:0] o_operand_b,
  output logic [5:0]  o_func,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_dest,
  output logic        o_illegal
);

  if (FWD_DEPTH != 1) begin : g_bad_fwd_depth
    $error("alu_issue: FWD_DEPTH must be 1");
  end

  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic        w_is_rtype;
  logic        w_is_addi;
  logic        w_r_legal;
  logic        w_legal;
  logic        w_e_hit;
  logic        w_w_match_rs;
  logic        w_w_match_rt;
  logic        w_hazard;
  logic        w_accept;
  logic [31:0] w_src_a;
  logic [31:0] w_src_b;
  logic [31:0] w_next_a;
  logic [31:0] w_next_b;
  logic [5:0]  w_next_func;
  logic [4:0]  w_next_dest;

  logic        r_e_valid;
  logic [4:0]  r_e_dest;
  logic [31:0] r_e_a;
  logic [31:0] r_e_b;
  logic [5:0]  r_e_func;
  logic        r_w_valid;
  logic [4:0]  r_w_dest;
  logic        r_illegal;

  assign w_opcode   = i_instr[31:26];
  assign w_rs       = i_instr[25:21];
  assign w_rt       = i_instr[20:16];
  assign w_rd       = i_instr[15:11];
  assign w_shamt    = i_instr[10:6];
  assign w_funct    = i_instr[5:0];
  assign w_imm      = i_instr[15:0];
  assign w_is_rtype = (w_opcode == 6'd0);
  assign w_is_addi  = (w_opcode == 6'd8);

  always_comb begin
    w_r_legal = 1'b0;
    case (w_funct)
      6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7,
      6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd43: w_r_legal = 1'b1;
      default:                                  w_r_legal = 1'b0;
    endcase
  end

  assign w_legal = (w_is_rtype & w_r_legal) | w_is_addi;

  // rs is treated as read by every instruction; rt only by R-type.
  assign w_e_hit = r_e_valid && (r_e_dest != 5'd0) &&
                   ((w_rs == r_e_dest) || (w_is_rtype && (w_rt == r_e_dest)));
  assign w_w_match_rs = r_w_valid && (r_w_dest != 5'd0) && (w_rs == r_w_dest);
  assign w_w_match_rt = r_w_valid && (r_w_dest != 5'd0) && (w_rt == r_w_dest);

`ifdef ALU_ISSUE_FWD_EN
  assign w_hazard = w_e_hit;
  assign w_src_a  = w_w_match_rs ? i_alu_result : i_rs_data;
  assign w_src_b  = w_w_match_rt ? i_alu_result : i_rt_data;
`else
  logic w_unused_alu;
  assign w_unused_alu = ^i_alu_result;
  // Without forwarding the producer must also clear W before its value is readable.
  assign w_hazard = w_e_hit | w_w_match_rs | (w_is_rtype & w_w_match_rt);
  assign w_src_a  = i_rs_data;
  assign w_src_b  = i_rt_data;
`endif

  assign o_in_ready = i_clk_en & ~i_flush & ~w_hazard;
  assign w_accept   = i_in_valid & o_in_ready;

  always_comb begin
    w_next_a    = w_src_a;
    w_next_b    = w_src_b;
    w_next_func = w_funct;
    w_next_dest = w_rd;
    if (w_is_addi) begin
      w_next_func = 6'd8;
      w_next_b    = {{16{w_imm[15]}}, w_imm};
      w_next_dest = w_rt;
    end else begin
      case (w_funct)
        6'd0, 6'd2, 6'd3: w_next_a = {27'b0, w_shamt};
        6'd4, 6'd6, 6'd7: w_next_a = {27'b0, w_src_a[4:0]};
        default:          w_next_a = w_src_a;
      endcase
    end
  end

  // Stalls, idle cycles and illegal instructions all issue a bubble into E.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_e_valid <= 1'b0;
      r_e_dest  <= 5'd0;
      r_e_a     <= 32'd0;
      r_e_b     <= 32'd0;
      r_e_func  <= 6'd0;
      r_w_valid <= 1'b0;
      r_w_dest  <= 5'd0;
      r_illegal <= 1'b0;
    end else if (i_clk_en) begin
      if (i_flush) begin
        r_e_valid <= 1'b0;
        r_e_dest  <= 5'd0;
        r_e_a     <= 32'd0;
        r_e_b     <= 32'd0;
        r_e_func  <= 6'd0;
        r_w_valid <= 1'b0;
        r_w_dest  <= 5'd0;
        r_illegal <= 1'b0;
      end else begin
        r_w_valid <= r_e_valid;
        r_w_dest  <= r_e_dest;
        r_illegal <= w_accept & ~w_legal;
        if (w_accept && w_legal) begin
          r_e_valid <= 1'b1;
          r_e_dest  <= w_next_dest;
          r_e_a     <= w_next_a;
          r_e_b     <= w_next_b;
          r_e_func  <= w_next_func;
        end else begin
          r_e_valid <= 1'b0;
          r_e_dest  <= 5'd0;
          r_e_a     <= 32'd0;
          r_e_b     <= 32'd0;
          r_e_func  <= 6'd0;
        end
      end
    end
  end

  assign o_operand_a = r_e_a;
  assign o_operand_b = r_e_b;
  assign o_func      = r_e_func;
  assign o_wb_valid  = r_w_valid & (r_w_dest != 5'd0);
  assign o_wb_dest   = r_w_dest;
  assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural one-cycle ALU closing the forwarding loop.
// Hazard expectations follow ALU_ISSUE_FWD_EN the same way the design does.
module tb_alu_issue;

  localparam logic [31:0] ADD3  = 32'h00221820;
  localparam logic [31:0] ADDI4 = 32'h2024FFFF;
  localparam logic [31:0] SUB5  = 32'h00612822;
  localparam logic [31:0] SLL2  = 32'h00011100;
  localparam logic [31:0] LW5   = 32'h8C250000;
  localparam logic [31:0] OR6   = 32'h00223025;
  localparam logic [31:0] AND7  = 32'h00223824;

  logic        clk = 1'b0;
  logic        rst;
  logic        clkEn;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] instr;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [31:0] aluResult = 32'd0;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [5:0]  func;
  logic        wbValid;
  logic [4:0]  wbDest;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue #(.FWD_DEPTH(1)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clk_en     (clkEn),
    .i_flush      (flush),
    .i_in_valid   (inValid),
    .o_in_ready   (inReady),
    .i_instr      (instr),
    .i_rs_data    (rsData),
    .i_rt_data    (rtData),
    .i_alu_result (aluResult),
    .o_operand_a  (operandA),
    .o_operand_b  (operandB),
    .o_func       (func),
    .o_wb_valid   (wbValid),
    .o_wb_dest    (wbDest),
    .o_illegal    (illegal)
  );

  function automatic logic [31:0] aluModel(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      6'd0, 6'd4:  return b << a[4:0];
      6'd2, 6'd6:  return b >> a[4:0];
      6'd3, 6'd7:  return $unsigned($signed(b) >>> a[4:0]);
      6'd8, 6'd32: return a + b;
      6'd34:       return a - b;
      6'd36:       return a & b;
      6'd37:       return a | b;
      6'd38:       return a ^ b;
      6'd43:       return {31'd0, a < b};
      default:     return 32'd0;
    endcase
  endfunction

  // Downstream ALU: registers its result one cycle after the operands are presented.
  always @(posedge clk) begin
    if (clkEn) aluResult <= aluModel(func, operandA, operandB);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    inValid = v;
    instr   = ins;
    rsData  = rs;
    rtData  = rt;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clkEn = 1'b1;
    flush = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    nextCycle();
    nextCycle();
    checkOutput("rst_opA", operandA, 32'd0);
    checkOutput("rst_opB", operandB, 32'd0);
    checkOutput("rst_func", {26'd0, func}, 32'd0);
    checkOutput("rst_wbValid", {31'd0, wbValid}, 32'd0);
    checkOutput("rst_wbDest", {27'd0, wbDest}, 32'd0);
    checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_inReady", {31'd0, inReady}, 32'd1);

    $display("[TB] basic add");
    applyStimulus(1'b1, ADD3, 32'd5, 32'd7);
    #1;
    checkOutput("add_inReady", {31'd0, inReady}, 32'd1);
    nextCycle();
    checkOutput("add_opA", operandA, 32'd5);
    checkOutput("add_opB", operandB, 32'd7);
    checkOutput("add_func", {26'd0, func}, 32'd32);
    checkOutput("add_wbEarly", {31'd0, wbValid}, 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    nextCycle();
    checkOutput("add_wbValid", {31'd0, wbValid}, 32'd1);
    checkOutput("add_wbDest", {27'd0, wbDest}, 32'd3);
    checkOutput("add_result", aluResult, 32'd12);
    checkOutput("add_bubbleA", operandA, 32'd0);
    nextCycle();
    checkOutput("add_wbDone", {31'd0, wbValid}, 32'd0);

    $display("[TB] addi sign extension");
    applyStimulus(1'b1, ADDI4, 32'd10, 32'd99);
    nextCycle();
    checkOutput("addi_opA", operandA, 32'd10);
    checkOutput("addi_opB", operandB, 32'hFFFFFFFF);
    checkOutput("addi_func", {26'd0, func}, 32'd8);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    nextCycle();
    checkOutput("addi_wbValid", {31'd0, wbValid}, 32'd1);
    checkOutput("addi_wbDest", {27'd0, wbDest}, 32'd4);
    checkOutput("addi_result", aluResult, 32'd9);
    nextCycle();

    $display("[TB] hazard and forward");
    applyStimulus(1'b1, ADD3, 32'd5, 32'd7);
    #1;
    checkOutput("haz_prodReady", {31'd0, inReady}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, SUB5, 32'hDEAD0000, 32'd5);
    #1;
    checkOutput("haz_stall1", {31'd0, inReady}, 32'd0);
    nextCycle();
`ifdef ALU_ISSUE_FWD_EN
    checkOutput("haz_fwdReady", {31'd0, inReady}, 32'd1);
    nextCycle();
`else
    checkOutput("haz_stall2", {31'd0, inReady}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, SUB5, 32'd12, 32'd5);
    #1;
    checkOutput("haz_noFwdReady", {31'd0, inReady}, 32'd1);
    nextCycle();
`endif
    checkOutput("haz_opA", operandA, 32'd12);
    checkOutput("haz_opB", operandB, 32'd5);
    checkOutput("haz_func", {26'd0, func}, 32'd34);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    nextCycle();
    checkOutput("haz_wbValid", {31'd0, wbValid}, 32'd1);
    checkOutput("haz_wbDest", {27'd0, wbDest}, 32'd5);
    checkOutput("haz_result", aluResult, 32'd7);
    nextCycle();

    $display("[TB] shift and illegal");
    applyStimulus(1'b1, SLL2, 32'h55, 32'd1);
    nextCycle();
    checkOutput("sll_opA", operandA, 32'd4);
    checkOutput("sll_opB", operandB, 32'd1);
    checkOutput("sll_func", {26'd0, func}, 32'd0);
    applyStimulus(1'b1, LW5, 32'd0, 32'd0);
    nextCycle();
    checkOutput("sll_wbValid", {31'd0, wbValid}, 32'd1);
    checkOutput("sll_wbDest", {27'd0, wbDest}, 32'd2);
    checkOutput("sll_result", aluResult, 32'd16);
    checkOutput("lw_illegal", {31'd0, illegal}, 32'd1);
    checkOutput("lw_bubbleA", operandA, 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    nextCycle();
    checkOutput("lw_illegalPulse", {31'd0, illegal}, 32'd0);
    checkOutput("lw_noWb1", {31'd0, wbValid}, 32'd0);
    nextCycle();
    checkOutput("lw_noWb2", {31'd0, wbValid}, 32'd0);

    $display("[TB] flush");
    applyStimulus(1'b1, ADD3, 32'd5, 32'd7);
    nextCycle();
    checkOutput("fl_accepted", operandA, 32'd5);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    flush = 1'b1;
    #1;
    checkOutput("fl_inReady", {31'd0, inReady}, 32'd0);
    nextCycle();
    flush = 1'b0;
    checkOutput("fl_wb1", {31'd0, wbValid}, 32'd0);
    checkOutput("fl_opA", operandA, 32'd0);
    checkOutput("fl_func", {26'd0, func}, 32'd0);
    nextCycle();
    checkOutput("fl_wb2", {31'd0, wbValid}, 32'd0);

    $display("[TB] clock enable freeze");
    applyStimulus(1'b1, OR6, 32'd3, 32'd5);
    nextCycle();
    checkOutput("ce_orA", operandA, 32'd3);
    checkOutput("ce_orFunc", {26'd0, func}, 32'd37);
    applyStimulus(1'b1, AND7, 32'd6, 32'd12);
    clkEn = 1'b0;
    #1;
    checkOutput("ce_inReadyLow", {31'd0, inReady}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("ce_holdA", operandA, 32'd3);
      checkOutput("ce_holdB", operandB, 32'd5);
      checkOutput("ce_holdFunc", {26'd0, func}, 32'd37);
      checkOutput("ce_holdWb", {31'd0, wbValid}, 32'd0);
    end
    clkEn = 1'b1;
    #1;
    checkOutput("ce_inReadyBack", {31'd0, inReady}, 32'd1);
    nextCycle();
    checkOutput("ce_andA", operandA, 32'd6);
    checkOutput("ce_andB", operandB, 32'd12);
    checkOutput("ce_andFunc", {26'd0, func}, 32'd36);
    checkOutput("ce_orWbValid", {31'd0, wbValid}, 32'd1);
    checkOutput("ce_orWbDest", {27'd0, wbDest}, 32'd6);
    checkOutput("ce_orResult", aluResult, 32'd7);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    nextCycle();
    checkOutput("ce_andWbValid", {31'd0, wbValid}, 32'd1);
    checkOutput("ce_andWbDest", {27'd0, wbDest}, 32'd7);
    checkOutput("ce_andResult", aluResult, 32'd4);
    nextCycle();
    checkOutput("ce_noDup", {31'd0, wbValid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-issue stage directly upstream of the ALU. It accepts one decoded instruction per cycle over a valid/ready handshake and selects `operand_a`, `operand_b` and `func` for the ALU. It tracks the destination register through the ALU's one-cycle registered latency, so that `wb_valid`/`wb_dest` line up with `alu_result`. It also resolves read-after-write hazards by forwarding `alu_result` and by interlocking.

## Interface
- `FWD_DEPTH`, default 1: number of ALU result registers between issue and writeback; fixed at 1 for this ALU, and any other value is illegal.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clk_en` in 1: global clock enable; low freezes all state.
- `flush` in 1: synchronous kill of all in-flight work.
- `in_valid` in 1: instruction present on `instr`/`rs_data`/`rt_data`.
- `in_ready` out 1: stage accepts this cycle.
- `instr` in 32: MIPS instruction word.
- `rs_data`, `rt_data` in 32 each: register-file reads, combinational, without write-through.
- `alu_result` in 32: registered ALU output, fed back for forwarding.
- `operand_a`, `operand_b` out 32 each: to the ALU.
- `func` out 6: to the ALU.
- `wb_valid` out 1: `alu_result` is to be written this cycle.
- `wb_dest` out 5: writeback register.
- `illegal` out 1: one-cycle pulse when an unsupported instruction is consumed.

## Operation
- Decode rules:
  - R-type (opcode 0), funct in {0,2,3,4,6,7,32,34,36,37,38,43}: `func` = funct; dest = rd.
  - Shift-immediate (funct 0/2/3): `operand_a` = zero-extended shamt; `operand_b` = rt.
  - Variable shift (funct 4/6/7): `operand_a` = {27'b0, rs[4:0]}; `operand_b` = rt.
  - Other R-type ops: `operand_a` = rs; `operand_b` = rt.
  - addi (opcode 8): `func` = 8; `operand_a` = rs; `operand_b` = sign-extended imm[15:0]; dest = rt.
  - Anything else is illegal: the instruction is consumed, `illegal` pulses, and a bubble is issued.
- Pipeline state:
  - E register: valid, dest, operands, func.
  - W register: valid, dest; one cycle behind E, aligned with `alu_result`.
- A bubble or reset drives `operand_a` = 0, `operand_b` = 0, `func` = 0, E valid = 0.
- Accept condition: `in_valid & in_ready`. `in_ready = clk_en & ~flush & ~hazard`.
- Hazard: E is valid, E dest ≠ 0, and the new instruction reads that dest (rs always read; rt read for R-type only). This stalls for exactly one cycle. On the next cycle the producer is in W and is forwarded.
- Forwarding: if W is valid, W dest ≠ 0, and a source register equals W dest, the value comes from `alu_result` instead of `rs_data`/`rt_data`. rs and rt are checked independently.
- Register 0: dest 0 never sets `wb_valid` and never matches a hazard or forward.
- Stalled or no-accept cycles load a bubble into E. W always takes E on an enabled edge.
- flush: E and W are cleared on the same edge, no accept occurs, and `illegal` is cleared.
- `rst` has priority over `flush`, which has priority over accept.
- `clk_en` low: all registers hold. The consumer must qualify `wb_valid` with `clk_en`.

## Timing
- Reset values: `operand_a` 0, `operand_b` 0, `func` 0, `wb_valid` 0, `wb_dest` 0, `illegal` 0. `in_ready` follows its equation (1 when `clk_en` is high and no flush).
- Accept at edge t: operands and func are valid after t. The ALU registers the result at t+1. `wb_valid`/`wb_dest`/`alu_result` are valid in the cycle after t+1.
- Back-to-back independent instructions run at throughput 1 per cycle.
- A dependent instruction immediately following its producer costs one bubble. A dependency with one independent instruction between costs zero.
- `illegal` is asserted in the cycle after the consuming edge.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding from `alu_result` as above.
- `ALU_ISSUE_FWD_EN` undefined: there is no forwarding mux. Hazard also covers a valid W with matching dest ≠ 0, so a back-to-back dependent instruction stalls two cycles. Operands always come from `rs_data`/`rt_data`.

## Test plan
- Reset: hold `rst` for 2 cycles → all outputs 0 and `wb_valid` 0. After `rst` falls, `in_ready` = 1 with `clk_en` = 1.
- Basic add: `add $3,$1,$2` with rs = 5, rt = 7 → `func` = 32, operands 5/7. Two edges later `wb_valid` = 1, `wb_dest` = 3, `alu_result` = 12.
- addi sign extension: `addi $4,$1,-1` with rs = 10 → `operand_b` = 32'hFFFFFFFF, `func` = 8, `wb_dest` = 4, result = 9.
- Hazard and forward: `add $3,$1,$2` then `sub $5,$3,$1` back-to-back.
  - FWD_EN: one cycle with `in_ready` = 0; then `operand_a` = forwarded 12.
  - No FWD_EN: two stall cycles.
- Shift and illegal: `sll $2,$1,4` with rt = 1 → `operand_a` = 4, `func` = 0, result = 16. Opcode 0x23 (lw) → `illegal` pulses 1 cycle and no `wb_valid` follows.
- Flush and clk_en:
  - `flush` on the cycle after an accept → `wb_valid` never asserts.
  - `clk_en` = 0 for 3 cycles mid-stream → all outputs hold and `in_ready` = 0. The stream resumes with no loss or duplication.
